analog_signal_acquisition: RTL and testbench
============================================

Name: analog_signal_acquisition

Overview:
- Capture-side counterpart of the DAC waveform generator: receives 12-bit ADC samples, applies optional decimation, triggers on a level crossing or by force, and stores a pre/post-trigger window in a circular buffer.
- Configured, armed and read back over the same opcode/addr/data command bus the generator uses, on opcodes 0x40-0x46.
- Sits beside the generator so loopback (DAC out -> ADC in) can be captured and checked.

Parameters:
- DEPTH, 1024, capture buffer depth in samples (power of two).
- ADDR_W, 10, log2(DEPTH).
- DATA_W, 12, ADC sample width.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  reset; synchronous, active-high.
- adc_data  in  DATA_W  ADC sample, valid when adc_valid=1.
- adc_valid  in  1  one-cycle sample strobe.
- cmd_opcode  in  8  command opcode.
- cmd_addr  in  16  buffer read index (opcode 0x45).
- cmd_data  in  32  command payload.
- cmd_valid  in  1  command strobe, one cycle per command.
- resp_data  out  32  read-back data.
- resp_valid  out  1  one-cycle pulse qualifying resp_data.
- busy  out  1  high in PRETRIG, ARMED or POST.
- capture_done  out  1  one-cycle pulse when the window completes.

Behaviour:
- Reset:
  - all outputs 0; state IDLE; pointers, counters and config registers 0.
  - decimation register = 1.
  - buffer contents undefined.
- Commands (one per cmd_valid):
  - 0x40 config: bit0 edge (0 rising, 1 falling); bit1 force (1 = trigger on first eligible sample).
  - 0x41 trigger level = data[11:0].
  - 0x42 pre-trigger count = data[9:0], clamped to DEPTH-1.
  - 0x43 decimation = data[15:0]; values 0 and 1 both mean every sample.
  - 0x44 data[0]=1 arms from any state (restarts a capture in progress); data[0]=0 aborts to IDLE.
  - 0x45 read buffer at index cmd_addr[ADDR_W-1:0].
  - 0x46 read status.
  - Other opcodes are ignored.
- Config latching: config, level, pre-trigger and decimation writes update registers immediately but are copied to working copies only on arm. A write mid-capture does not affect that capture.
- Decimation: a counter reloads to dec-1 on arm. Each adc_valid either decrements the counter or, when it is 0, produces an accepted sample and reloads. Only accepted samples are written to the buffer or checked for trigger.
- State machine:
  - IDLE: no writes.
  - Arm -> PRETRIG: wr_ptr=0, fill count=0, prev-sample-valid=0.
  - PRETRIG: write accepted samples at wr_ptr and increment it (wraps mod DEPTH). When the fill count reaches pre, go to ARMED; if pre=0, go directly to ARMED.
  - ARMED: write continues and the pointer wraps. Trigger when force=1, or on a rising crossing (prev < level and cur >= level), or on a falling crossing (prev >= level and cur < level). A crossing requires prev-sample-valid. On trigger: trig_ptr = wr_ptr of the trigger sample; post count = DEPTH-pre-1; go to POST.
  - POST: each accepted sample decrements the post count. When the count is 0 and a sample is accepted, go to DONE and pulse capture_done. If post count = 0 at entry, DONE follows the next cycle.
  - DONE: holds until arm or abort. No further writes.
- Window addressing:
  - start_ptr = trig_ptr - pre (mod DEPTH).
  - Read index k maps to physical address (start_ptr + k) mod DEPTH.
  - Index pre is the trigger sample.
- Read latency:
  - 0x45 and 0x46 both return resp_valid exactly 2 cycles after cmd_valid.
  - 0x45: resp_data = {20'b0, sample}.
  - 0x46: resp_data = {6'b0, trig_ptr[9:0], 12'b0, done, state[2:0]}.
- Reads are allowed in any state. A read during capture returns current RAM contents. On a same-cycle read and write to one address, the read returns old data.
- Mid-operation: arm during capture restarts from PRETRIG. rst during any state returns to IDLE with no capture_done.
- Priority: arm/abort in the same cycle as a trigger wins; no transition to POST.

Decomposition:
- Package acq_pkg holds:
  - opcode constants ACQ_OP_CFG=0x40 through ACQ_OP_STATUS=0x46;
  - state encoding IDLE=0, PRETRIG=1, ARMED=2, POST=3, DONE=4;
  - status bit positions.
- Sub-module acq_sample_ram: simple dual-port DEPTH x DATA_W RAM with a registered read port and a separate write port.

Test Plan:
- Ramp 0..4095 on every cycle; level 2000, rising, pre 16, dec 1, arm -> capture_done; index 16 reads 2000, index 15 reads 1999, index 1023 reads 3007.
- Same ramp with force=1, pre 0 -> trigger on first accepted sample (value v); index k reads v+k; status shows DONE, done=1.
- Decimation 4, ramp step 1 -> consecutive indices differ by 4; the trigger sample is the first accepted value >= level.
- Falling edge, level 1000, descending ramp from 3000 -> index pre reads 999; a constant input of 500 never triggers (busy stays 1).
- Abort in ARMED -> state IDLE, no capture_done. Re-arm mid-POST -> PRETRIG restart; the capture completes normally afterwards.
- Read commands (0x45 and 0x46) back-to-back -> resp_valid exactly 2 cycles after each cmd_valid. rst asserted mid-POST -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/acq_pkg.sv
// Shared opcodes, FSM encoding and status-word layout for the ADC capture block.
package acq_pkg;

    localparam logic [7:0] ACQ_OP_CFG    = 8'h40;
    localparam logic [7:0] ACQ_OP_LEVEL  = 8'h41;
    localparam logic [7:0] ACQ_OP_PRE    = 8'h42;
    localparam logic [7:0] ACQ_OP_DEC    = 8'h43;
    localparam logic [7:0] ACQ_OP_ARM    = 8'h44;
    localparam logic [7:0] ACQ_OP_READ   = 8'h45;
    localparam logic [7:0] ACQ_OP_STATUS = 8'h46;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRETRIG = 3'd1,
        ARMED   = 3'd2,
        POST    = 3'd3,
        DONE    = 3'd4
    } acq_state_t;

    localparam int STAT_STATE_LSB = 0;
    localparam int STAT_DONE_BIT  = 3;
    localparam int STAT_TRIG_LSB  = 16;

    function automatic logic [31:0] pack_status(input logic [9:0] trig,
                                                input logic       done,
                                                input logic [2:0] st);
        logic [31:0] s;
        s = '0;
        s[STAT_STATE_LSB +: 3] = st;
        s[STAT_DONE_BIT]       = done;
        s[STAT_TRIG_LSB +: 10] = trig;
        return s;
    endfunction

    // Decimation of 0 and 1 both mean "keep every sample".
    function automatic logic [15:0] dec_reload(input logic [15:0] d);
        return (d <= 16'd1) ? 16'd0 : d - 16'd1;
    endfunction

endpackage

// File: rtl/acq_sample_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old word.
module acq_sample_ram #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/analog_signal_acquisition.sv
// ADC capture engine: decimation, level/force trigger and a pre/post-trigger
// window in a circular buffer, controlled over the generator's command bus.
module analog_signal_acquisition
    import acq_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    input  logic [7:0]        cmd_opcode,
    input  logic [15:0]       cmd_addr,
    input  logic [31:0]       cmd_data,
    input  logic              cmd_valid,
    output logic [31:0]       resp_data,
    output logic              resp_valid,
    output logic              busy,
    output logic              capture_done
);

    acq_state_t        state;
    logic              cfg_edge, cfg_force, w_edge, w_force;
    logic [DATA_W-1:0] level_reg, w_level, prev_sample;
    logic [ADDR_W-1:0] pre_reg, w_pre;
    logic [15:0]       dec_reg, w_dec, dec_cnt;
    logic [ADDR_W-1:0] wr_ptr, fill_cnt, post_cnt, trig_ptr;
    logic              prev_valid;

    logic              capturing, arm_cmd, accept, wr_en, trig_hit;
    logic              rising, falling;
    logic [ADDR_W-1:0] start_ptr, rd_addr;
    logic [DATA_W-1:0] ram_q;
    logic              rd_pend, rd_is_status;
    logic [31:0]       status_q;
    logic              unused_bits;

    assign unused_bits = ^{cmd_data[31:16], cmd_addr[15:ADDR_W]};

    assign capturing = (state == PRETRIG) || (state == ARMED) || (state == POST);
    assign busy      = capturing;
    assign arm_cmd   = cmd_valid && (cmd_opcode == ACQ_OP_ARM);
    // Arm/abort pre-empts whatever the current sample would have done.
    assign accept    = adc_valid && capturing && (dec_cnt == 16'd0) && !arm_cmd;
    assign wr_en     = accept && !((state == POST) && (post_cnt == '0));

    assign rising   = prev_valid && (prev_sample <  w_level) && (adc_data >= w_level);
    assign falling  = prev_valid && (prev_sample >= w_level) && (adc_data <  w_level);
    assign trig_hit = w_force || (w_edge ? falling : rising);

    assign start_ptr = trig_ptr - w_pre;
    assign rd_addr   = start_ptr + cmd_addr[ADDR_W-1:0];

    acq_sample_ram #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(wr_ptr),
        .wr_data(adc_data),
        .rd_addr(rd_addr),
        .rd_data(ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cfg_edge     <= 1'b0;
            cfg_force    <= 1'b0;
            w_edge       <= 1'b0;
            w_force      <= 1'b0;
            level_reg    <= '0;
            w_level      <= '0;
            prev_sample  <= '0;
            pre_reg      <= '0;
            w_pre        <= '0;
            dec_reg      <= 16'd1;
            w_dec        <= 16'd0;
            dec_cnt      <= 16'd0;
            wr_ptr       <= '0;
            fill_cnt     <= '0;
            post_cnt     <= '0;
            trig_ptr     <= '0;
            prev_valid   <= 1'b0;
            capture_done <= 1'b0;
        end else begin
            capture_done <= 1'b0;

            if (adc_valid && capturing) begin
                dec_cnt <= (dec_cnt == 16'd0) ? dec_reload(w_dec) : dec_cnt - 16'd1;
            end

            case (state)
                PRETRIG: begin
                    if (accept) begin
                        wr_ptr      <= wr_ptr + 1'b1;
                        fill_cnt    <= fill_cnt + 1'b1;
                        prev_sample <= adc_data;
                        prev_valid  <= 1'b1;
                        if (fill_cnt == w_pre - 1'b1) begin
                            state <= ARMED;
                        end
                    end
                end
                ARMED: begin
                    if (accept) begin
                        wr_ptr      <= wr_ptr + 1'b1;
                        prev_sample <= adc_data;
                        prev_valid  <= 1'b1;
                        if (trig_hit) begin
                            trig_ptr <= wr_ptr;
                            post_cnt <= ADDR_W'(DEPTH - 1) - w_pre;
                            state    <= POST;
                        end
                    end
                end
                POST: begin
                    if (post_cnt == '0) begin
                        state        <= DONE;
                        capture_done <= 1'b1;
                    end else if (accept) begin
                        wr_ptr   <= wr_ptr + 1'b1;
                        post_cnt <= post_cnt - 1'b1;
                        if (post_cnt == ADDR_W'(1)) begin
                            state        <= DONE;
                            capture_done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            // Config writes only reach the working copies when a capture is armed.
            if (cmd_valid) begin
                case (cmd_opcode)
                    ACQ_OP_CFG: begin
                        cfg_edge  <= cmd_data[0];
                        cfg_force <= cmd_data[1];
                    end
                    ACQ_OP_LEVEL: level_reg <= cmd_data[DATA_W-1:0];
                    ACQ_OP_PRE:   pre_reg <= (int'(cmd_data[9:0]) > DEPTH - 1) ?
                                             ADDR_W'(DEPTH - 1) : ADDR_W'(cmd_data[9:0]);
                    ACQ_OP_DEC:   dec_reg <= cmd_data[15:0];
                    ACQ_OP_ARM: begin
                        capture_done <= 1'b0;
                        if (cmd_data[0]) begin
                            state      <= (pre_reg == '0) ? ARMED : PRETRIG;
                            w_edge     <= cfg_edge;
                            w_force    <= cfg_force;
                            w_level    <= level_reg;
                            w_pre      <= pre_reg;
                            w_dec      <= dec_reg;
                            dec_cnt    <= dec_reload(dec_reg);
                            wr_ptr     <= '0;
                            fill_cnt   <= '0;
                            prev_valid <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Two-stage read pipeline: RAM/status capture, then the response register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend      <= 1'b0;
            rd_is_status <= 1'b0;
            status_q     <= '0;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
        end else begin
            rd_pend      <= cmd_valid && ((cmd_opcode == ACQ_OP_READ) ||
                                          (cmd_opcode == ACQ_OP_STATUS));
            rd_is_status <= (cmd_opcode == ACQ_OP_STATUS);
            status_q     <= pack_status(10'(trig_ptr), state == DONE, state);
            resp_valid   <= rd_pend;
            if (rd_pend) begin
                resp_data <= rd_is_status ? status_q : 32'(ram_q);
            end
        end
    end

endmodule

// File: tb/tb_analog_signal_acquisition.sv
// Directed bench for analog_signal_acquisition: ramp captures, decimation,
// falling edge, abort, re-arm, read latency and mid-capture reset.
module tb_analog_signal_acquisition;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] adc_data;
    logic        adc_valid;
    logic [7:0]  cmd_opcode;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_data;
    logic        cmd_valid;
    logic [31:0] resp_data;
    logic        resp_valid;
    logic        busy;
    logic        capture_done;

    int          checks = 0;
    int          errors = 0;
    int          done_count = 0;
    logic        ramp_on = 1'b0;
    logic [11:0] ramp_val = 12'd0;
    int          ramp_step = 1;

    always #5 clk = ~clk;

    analog_signal_acquisition dut (
        .clk         (clk),
        .rst         (rst),
        .adc_data    (adc_data),
        .adc_valid   (adc_valid),
        .cmd_opcode  (cmd_opcode),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .cmd_valid   (cmd_valid),
        .resp_data   (resp_data),
        .resp_valid  (resp_valid),
        .busy        (busy),
        .capture_done(capture_done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One clock per call: count done pulses seen, then drive ADC and command bus.
    task automatic applyStimulus(input logic [7:0] op, input logic [15:0] addr,
                                 input logic [31:0] data, input logic valid);
        @(negedge clk);
        if (capture_done === 1'b1) done_count++;
        if (ramp_on) begin
            adc_valid = 1'b1;
            adc_data  = ramp_val;
            ramp_val  = 12'(int'(ramp_val) + ramp_step);
        end else begin
            adc_valid = 1'b0;
        end
        cmd_opcode = op;
        cmd_addr   = addr;
        cmd_data   = data;
        cmd_valid  = valid;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(8'h00, 16'h0, 32'h0, 1'b0);
    endtask

    task automatic sendCmd(input logic [7:0] op, input logic [31:0] data);
        applyStimulus(op, 16'h0, data, 1'b1);
    endtask

    task automatic readCmd(input logic [7:0] op, input logic [15:0] addr,
                           output logic [31:0] data);
        applyStimulus(op, addr, 32'h0, 1'b1);
        idleCycles(1);
        checkOutput("resp_not_early", 32'(resp_valid), 32'd0);
        idleCycles(1);
        checkOutput("resp_at_2", 32'(resp_valid), 32'd1);
        data = resp_data;
    endtask

    task automatic readIdx(input string tag, input int k, input int expected);
        logic [31:0] d;
        readCmd(8'h45, 16'(k), d);
        checkOutput(tag, d, 32'(expected));
    endtask

    task automatic waitDone(input string tag, input int bound);
        int start;
        int n;
        start = done_count;
        n = 0;
        while (done_count == start && n < bound) begin
            idleCycles(1);
            n++;
        end
        ramp_on = 1'b0;
        checkOutput(tag, 32'(done_count - start), 32'd1);
    endtask

    task automatic startRamp(input logic [11:0] v, input int step);
        ramp_val  = v;
        ramp_step = step;
        ramp_on   = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] d;
        int          d0;

        rst = 1'b1; adc_valid = 1'b0; adc_data = '0;
        cmd_opcode = '0; cmd_addr = '0; cmd_data = '0; cmd_valid = 1'b0;
        idleCycles(3);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(capture_done), 32'd0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_resp_data", resp_data, 32'd0);
        rst = 1'b0;
        idleCycles(2);
        readCmd(8'h46, 16'h0, d);
        checkOutput("rst_status", d, 32'd0);

        $display("[TB] rising ramp, level 2000, pre 16");
        sendCmd(8'h40, 32'd0); sendCmd(8'h41, 32'd2000);
        sendCmd(8'h42, 32'd16); sendCmd(8'h43, 32'd1);
        sendCmd(8'h44, 32'd1);
        startRamp(12'd0, 1);
        waitDone("t1_done", 5000);
        idleCycles(3);
        checkOutput("t1_single_pulse", 32'(done_count), 32'd1);
        checkOutput("t1_busy_low", 32'(busy), 32'd0);
        readIdx("t1_idx16", 16, 2000);
        readIdx("t1_idx15", 15, 1999);
        readIdx("t1_idx1023", 1023, 3007);
        readIdx("t1_idx0", 0, 1984);
        readCmd(8'h46, 16'h0, d);
        checkOutput("t1_status", d, 32'h03D0_000C);

        $display("[TB] forced trigger, pre 0");
        sendCmd(8'h40, 32'd2); sendCmd(8'h42, 32'd0);
        sendCmd(8'h44, 32'd1);
        startRamp(12'd100, 1);
        waitDone("t2_done", 2000);
        readIdx("t2_idx0", 0, 100);
        readIdx("t2_idx500", 500, 600);
        readIdx("t2_idx1023", 1023, 1123);
        readCmd(8'h46, 16'h0, d);
        checkOutput("t2_status", d, 32'h0000_000C);

        $display("[TB] decimation 4, level 2001, pre 4");
        sendCmd(8'h40, 32'd0); sendCmd(8'h41, 32'd2001);
        sendCmd(8'h42, 32'd4); sendCmd(8'h43, 32'd4);
        sendCmd(8'h44, 32'd1);
        startRamp(12'd0, 1);
        waitDone("t3_done", 10000);
        readIdx("t3_idx4", 4, 2003);
        readIdx("t3_idx5", 5, 2007);
        readIdx("t3_idx3", 3, 1999);
        readIdx("t3_idx1023", 1023, 1983);
        sendCmd(8'h43, 32'd1);

        $display("[TB] falling edge, level 1000, pre 8");
        sendCmd(8'h40, 32'd1); sendCmd(8'h41, 32'd1000);
        sendCmd(8'h42, 32'd8); sendCmd(8'h44, 32'd1);
        startRamp(12'd3000, -1);
        waitDone("t4_done", 4000);
        readIdx("t4_idx8", 8, 999);
        readIdx("t4_idx7", 7, 1000);
        readIdx("t4_idx1023", 1023, 4080);
        readCmd(8'h46, 16'h0, d);
        checkOutput("t4_status", d, 32'h03D1_000C);

        $display("[TB] constant 500 never triggers, then abort");
        d0 = done_count;
        sendCmd(8'h44, 32'd1);
        startRamp(12'd500, 0);
        idleCycles(300);
        checkOutput("t5_busy_armed", 32'(busy), 32'd1);
        readCmd(8'h46, 16'h0, d);
        checkOutput("t5_state_armed", 32'(d[2:0]), 32'd2);
        sendCmd(8'h44, 32'd0);
        ramp_on = 1'b0;
        idleCycles(3);
        checkOutput("t5_abort_busy", 32'(busy), 32'd0);
        readCmd(8'h46, 16'h0, d);
        checkOutput("t5_abort_state", 32'(d[3:0]), 32'd0);
        checkOutput("t5_no_done", 32'(done_count - d0), 32'd0);

        $display("[TB] re-arm in POST");
        sendCmd(8'h40, 32'd0); sendCmd(8'h41, 32'd2000);
        sendCmd(8'h42, 32'd16); sendCmd(8'h44, 32'd1);
        startRamp(12'd0, 1);
        idleCycles(2100);
        readCmd(8'h46, 16'h0, d);
        checkOutput("t6_in_post", 32'(d[2:0]), 32'd3);
        d0 = done_count;
        sendCmd(8'h44, 32'd1);
        readCmd(8'h46, 16'h0, d);
        checkOutput("t6_restart_pretrig", 32'(d[2:0]), 32'd1);
        checkOutput("t6_no_done_on_rearm", 32'(done_count - d0), 32'd0);
        waitDone("t6_done", 8000);
        readIdx("t6_idx16", 16, 2000);
        readIdx("t6_idx15", 15, 1999);
        readIdx("t6_idx1023", 1023, 3007);

        $display("[TB] back-to-back reads");
        applyStimulus(8'h45, 16'd16, 32'h0, 1'b1);
        applyStimulus(8'h46, 16'h0, 32'h0, 1'b1);
        checkOutput("b2b_cycle1_valid", 32'(resp_valid), 32'd0);
        idleCycles(1);
        checkOutput("b2b_read_valid", 32'(resp_valid), 32'd1);
        checkOutput("b2b_read_data", resp_data, 32'd2000);
        idleCycles(1);
        checkOutput("b2b_status_valid", 32'(resp_valid), 32'd1);
        checkOutput("b2b_status_low", 32'(resp_data[3:0]), 32'hC);
        idleCycles(1);
        checkOutput("b2b_after_valid", 32'(resp_valid), 32'd0);

        $display("[TB] reset during POST");
        sendCmd(8'h44, 32'd1);
        startRamp(12'd0, 1);
        idleCycles(2100);
        readCmd(8'h46, 16'h0, d);
        checkOutput("t7_in_post", 32'(d[2:0]), 32'd3);
        d0 = done_count;
        rst = 1'b1;
        idleCycles(1);
        checkOutput("t7_rst_busy", 32'(busy), 32'd0);
        checkOutput("t7_rst_done", 32'(capture_done), 32'd0);
        checkOutput("t7_rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("t7_rst_resp_data", resp_data, 32'd0);
        rst = 1'b0;
        idleCycles(1200);
        ramp_on = 1'b0;
        idleCycles(2);
        checkOutput("t7_no_done_after_rst", 32'(done_count - d0), 32'd0);
        readCmd(8'h46, 16'h0, d);
        checkOutput("t7_status_idle", d, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
